// File: rtl/alu_issue_ctrl_if.sv
// Issue / ALU / writeback bundle for alu_issue_ctrl.
// slave = the controller, master = the decode / ALU / writeback side.
interface alu_issue_ctrl_if;
    // 32 + 32 + 5 + 4 + 4 = 77 bits; the controller latches this record as a flat vector
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1_idx;
        logic [3:0]  alu_op;
        logic        is_mul;
        logic        is_div;
        logic        is_rem;
        logic        is_unsigned;
    } instr_t;

    logic        issue_valid;
    logic        issue_ready;
    instr_t      issue_instr;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [31:0] issue_csr;
    logic [4:0]  issue_rd;
    logic        alu_enabled;
    instr_t      alu_instr;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_csr;
    logic [31:0] alu_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    modport slave (
        input  issue_valid, issue_instr, issue_rs1, issue_rs2, issue_csr, issue_rd,
        input  alu_rd, wb_ready,
        output issue_ready, alu_enabled, alu_instr, alu_rs1, alu_rs2, alu_csr,
        output wb_valid, wb_data, wb_rd
    );

    modport master (
        output issue_valid, issue_instr, issue_rs1, issue_rs2, issue_csr, issue_rd,
        output alu_rd, wb_ready,
        input  issue_ready, alu_enabled, alu_instr, alu_rs1, alu_rs2, alu_csr,
        input  wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the combinational ALU: latches one op, holds the ALU enabled
// for the op-class latency, patches div/rem corner cases, then offers writeback.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    output logic              o_busy,
    alu_issue_ctrl_if.slave   bus
);
    localparam int INSTR_W = 77;
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_rs1, r_rs2, r_csr, r_wb_data;
    logic [4:0]         r_rd, r_wb_rd;

    logic               w_issue_ready, w_accept, w_done;
    logic               w_div_cls, w_div_zero, w_div_ovf;
    logic [31:0]        w_result;
    logic [CNT_W-1:0]   w_lat_m1;

    // Accept during the writeback handshake too, so ops can issue back-to-back.
    assign w_issue_ready = !i_flush &&
                           ((r_state == S_IDLE) || (r_state == S_WB && bus.wb_ready));
    assign w_accept      = bus.issue_valid && w_issue_ready;
    assign w_done        = (r_state == S_EXEC) && (r_cnt == '0);

    assign bus.issue_ready = w_issue_ready;
    assign bus.alu_enabled = (r_state == S_EXEC);
    assign bus.alu_instr   = r_instr;
    assign bus.alu_rs1     = r_rs1;
    assign bus.alu_rs2     = r_rs2;
    assign bus.alu_csr     = r_csr;
    assign bus.wb_valid    = (r_state == S_WB);
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_rd       = r_wb_rd;
    assign o_busy          = (r_state != S_IDLE);

    always_comb begin
        w_lat_m1 = '0;
        if (bus.issue_instr.is_mul)
            w_lat_m1 = MUL_CNT;
        else if (bus.issue_instr.is_div || bus.issue_instr.is_rem)
            w_lat_m1 = DIV_CNT;
    end

    assign w_div_cls  = bus.alu_instr.is_div || bus.alu_instr.is_rem;
    assign w_div_zero = (r_rs2 == 32'd0);
    assign w_div_ovf  = !bus.alu_instr.is_unsigned &&
                        (r_rs1 == 32'h8000_0000) && (r_rs2 == 32'hFFFF_FFFF);

    // RISC-V defines div/rem results for these cases instead of trapping.
    always_comb begin
        w_result = bus.alu_rd;
        if (w_div_cls && w_div_zero)
            w_result = bus.alu_instr.is_rem ? r_rs1 : 32'hFFFF_FFFF;
        else if (w_div_cls && w_div_ovf)
            w_result = bus.alu_instr.is_rem ? 32'd0 : 32'h8000_0000;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state <= S_EXEC;
                    r_cnt   <= w_lat_m1;
                end
                S_EXEC: begin
                    if (r_cnt == '0)
                        r_state <= (r_rd == 5'd0) ? S_IDLE : S_WB;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                S_WB: if (bus.wb_ready) begin
                    r_state <= w_accept ? S_EXEC : S_IDLE;
                    r_cnt   <= w_lat_m1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_csr   <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_instr <= bus.issue_instr;
            r_rs1   <= bus.issue_rs1;
            r_rs2   <= bus.issue_rs2;
            r_csr   <= bus.issue_csr;
            r_rd    <= bus.issue_rd;
        end
    end

    // rd==0 results are discarded, so wb_data keeps the last real writeback.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wb_data <= '0;
            r_wb_rd   <= '0;
        end else if (!i_flush && w_done && r_rd != 5'd0) begin
            r_wb_data <= w_result;
            r_wb_rd   <= r_rd;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed tests plus randomized ops checked against
// an arithmetic reference model of the writeback value and per-class latency.
module tb_alu_issue_ctrl;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;
    localparam int K_ADD = 0, K_ADDI = 1, K_MUL = 2, K_DIV = 3, K_DIVU = 4, K_REM = 5, K_REMU = 6;

    logic clk = 1'b0;
    logic rst, flush, busy;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl_if ifc();

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .o_busy  (busy),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: plain results, but junk on div corner cases so the overrides show.
    always_comb begin
        ifc.alu_rd = 32'h5A5A_5A5A;
        case (ifc.alu_instr.alu_op)
            4'd0: ifc.alu_rd = ifc.alu_rs1 + ifc.alu_rs2;
            4'd1: ifc.alu_rd = ifc.alu_rs1 + ifc.alu_instr.imm;
            4'd2: ifc.alu_rd = ifc.alu_rs1 * ifc.alu_rs2;
            4'd3: if (ifc.alu_rs2 != 0 && !(ifc.alu_rs1 == 32'h8000_0000 && ifc.alu_rs2 == 32'hFFFF_FFFF))
                      ifc.alu_rd = $signed(ifc.alu_rs1) / $signed(ifc.alu_rs2);
            4'd4: if (ifc.alu_rs2 != 0) ifc.alu_rd = ifc.alu_rs1 / ifc.alu_rs2;
            4'd5: if (ifc.alu_rs2 != 0 && !(ifc.alu_rs1 == 32'h8000_0000 && ifc.alu_rs2 == 32'hFFFF_FFFF))
                      ifc.alu_rd = $signed(ifc.alu_rs1) % $signed(ifc.alu_rs2);
            4'd6: if (ifc.alu_rs2 != 0) ifc.alu_rd = ifc.alu_rs1 % ifc.alu_rs2;
            default: ifc.alu_rd = 32'h5A5A_5A5A;
        endcase
    end

    // Reference: 64-bit signed arithmetic gives the overflow results naturally.
    function automatic logic [31:0] spec_result(input int kind, input logic [31:0] a, b, imm);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (kind)
            K_ADD:  return a + b;
            K_ADDI: return a + imm;
            K_MUL:  return 32'(longint'(a) * longint'(b));
            K_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            K_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            K_REM:  return (b == 0) ? a : 32'(sa % sb);
            K_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input int kind);
        if (kind == K_MUL) return MUL_LAT;
        if (kind >= K_DIV) return DIV_LAT;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input int kind, input logic [31:0] a, b, imm, input logic [4:0] rd);
        ifc.issue_valid = 1'b1;
        ifc.issue_instr = '0;
        ifc.issue_instr.pc          = $urandom;
        ifc.issue_instr.imm         = imm;
        ifc.issue_instr.rs1_idx     = 5'($urandom);
        ifc.issue_instr.alu_op      = 4'(kind);
        ifc.issue_instr.is_mul      = (kind == K_MUL);
        ifc.issue_instr.is_div      = (kind == K_DIV || kind == K_DIVU);
        ifc.issue_instr.is_rem      = (kind == K_REM || kind == K_REMU);
        ifc.issue_instr.is_unsigned = (kind == K_DIVU || kind == K_REMU);
        ifc.issue_rs1 = a;
        ifc.issue_rs2 = b;
        ifc.issue_csr = $urandom;
        ifc.issue_rd  = rd;
    endtask

    // Leaves the bench in the cycle right after the issue handshake.
    task automatic issue_op(input int kind, input logic [31:0] a, b, imm, input logic [4:0] rd);
        int g = 0;
        drive_issue(kind, a, b, imm, rd);
        #1;
        while (!ifc.issue_ready && g < 20) begin
            step();
            g++;
        end
        chk("issue_ready", 32'(ifc.issue_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.issue_valid = 1'b0;
    endtask

    task automatic collect(input int kind, input logic [31:0] a, b, imm, input logic [4:0] rd,
                           input int bp, input bit release_wb);
        int L, n, en;
        bit seen;
        logic [31:0] exp;
        L = lat_of(kind);
        exp = spec_result(kind, a, b, imm);
        n = 1; en = 0; seen = 0;
        if (rd == 5'd0) begin
            for (int i = 0; i < L; i++) begin
                if (ifc.wb_valid) seen = 1;
                step();
            end
            chk("rd0_idle_busy", 32'(busy), 32'd0);
            chk("rd0_no_wb", 32'(seen | ifc.wb_valid), 32'd0);
            return;
        end
        while (!ifc.wb_valid && n <= L + 5) begin
            if (ifc.alu_enabled) en++;
            step();
            n++;
        end
        chk("wb_latency", 32'(n), 32'(L + 1));
        chk("alu_en_cycles", 32'(en), 32'(L));
        chk("wb_data", ifc.wb_data, exp);
        chk("wb_rd", 32'(ifc.wb_rd), 32'(rd));
        for (int i = 0; i < bp; i++) begin
            step();
            chk("bp_valid", 32'(ifc.wb_valid), 32'd1);
            chk("bp_data", ifc.wb_data, exp);
            chk("bp_rd", 32'(ifc.wb_rd), 32'(rd));
            chk("bp_issue_ready", 32'(ifc.issue_ready), 32'd0);
        end
        if (release_wb) begin
            ifc.wb_ready = 1'b1;
            #1;
            chk("wb_issue_ready", 32'(ifc.issue_ready), 32'd1);
            step();
            ifc.wb_ready = 1'b0;
            chk("wb_drop", 32'(ifc.wb_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int kind, bp;
        logic [31:0] a, b, imm;
        logic [4:0] rd;

        rst = 1'b1; flush = 1'b0;
        ifc.issue_valid = 1'b0; ifc.issue_instr = '0; ifc.wb_ready = 1'b0;
        ifc.issue_rs1 = '0; ifc.issue_rs2 = '0; ifc.issue_csr = '0; ifc.issue_rd = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_issue_ready", 32'(ifc.issue_ready), 32'd1);
        chk("rst_wb_valid", 32'(ifc.wb_valid), 32'd0);
        chk("rst_alu_en", 32'(ifc.alu_enabled), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_data", ifc.wb_data, 32'd0);
        chk("rst_wb_rd", 32'(ifc.wb_rd), 32'd0);
        chk("rst_alu_rs1", ifc.alu_rs1, 32'd0);

        issue_op(K_ADDI, 32'd5, 32'd0, 32'd7, 5'd3);
        collect(K_ADDI, 32'd5, 32'd0, 32'd7, 5'd3, 0, 1);
        issue_op(K_MUL, 32'd6, 32'd7, 32'd0, 5'd4);
        collect(K_MUL, 32'd6, 32'd7, 32'd0, 5'd4, 0, 1);
        issue_op(K_DIV, 32'd100, 32'd7, 32'd0, 5'd5);
        collect(K_DIV, 32'd100, 32'd7, 32'd0, 5'd5, 0, 1);

        issue_op(K_DIVU, 32'h1234, 32'd0, 32'd0, 5'd6);
        collect(K_DIVU, 32'h1234, 32'd0, 32'd0, 5'd6, 0, 1);
        issue_op(K_REMU, 32'd9, 32'd0, 32'd0, 5'd7);
        collect(K_REMU, 32'd9, 32'd0, 32'd0, 5'd7, 0, 1);
        issue_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd8);
        collect(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd8, 0, 1);
        issue_op(K_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9);
        collect(K_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9, 0, 1);

        // Backpressure, then release together with the next issue.
        issue_op(K_ADD, 32'd10, 32'd20, 32'd0, 5'd10);
        collect(K_ADD, 32'd10, 32'd20, 32'd0, 5'd10, 5, 0);
        drive_issue(K_MUL, 32'd6, 32'd7, 32'd0, 5'd11);
        ifc.wb_ready = 1'b1;
        #1;
        chk("b2b_issue_ready", 32'(ifc.issue_ready), 32'd1);
        step();
        ifc.issue_valid = 1'b0;
        ifc.wb_ready = 1'b0;
        chk("b2b_exec", 32'(ifc.alu_enabled), 32'd1);
        chk("b2b_wb_drop", 32'(ifc.wb_valid), 32'd0);
        collect(K_MUL, 32'd6, 32'd7, 32'd0, 5'd11, 0, 1);

        // Flush on the third EXEC cycle of a div, with a competing issue.
        issue_op(K_DIV, 32'd100, 32'd7, 32'd0, 5'd12);
        step(); step();
        flush = 1'b1;
        drive_issue(K_ADD, 32'd1, 32'd2, 32'd0, 5'd13);
        #1;
        chk("flush_issue_ready", 32'(ifc.issue_ready), 32'd0);
        step();
        flush = 1'b0;
        ifc.issue_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_alu_en", 32'(ifc.alu_enabled), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (ifc.wb_valid || ifc.alu_enabled) seen = 1;
            step();
        end
        chk("flush_no_result", 32'(seen), 32'd0);

        // Flush while a result waits in writeback.
        issue_op(K_ADD, 32'd3, 32'd4, 32'd0, 5'd14);
        collect(K_ADD, 32'd3, 32'd4, 32'd0, 5'd14, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wb_valid", 32'(ifc.wb_valid), 32'd0);
        chk("flush_wb_busy", 32'(busy), 32'd0);

        issue_op(K_ADD, 32'd1, 32'd1, 32'd0, 5'd0);
        collect(K_ADD, 32'd1, 32'd1, 32'd0, 5'd0, 0, 1);

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 6);
            a    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0, 1:    b = 32'd0;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            imm  = $urandom;
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bp   = $urandom_range(0, 3);
            issue_op(kind, a, b, imm, rd);
            collect(kind, a, b, imm, rd, bp, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
